// File: rtl/scoreboard_display_ctrl_if.sv
// Score-update command channel: valid/ready handshake carrying team and command.
interface scoreboard_display_ctrl_if;
   logic       upd_valid;
   logic       upd_ready;
   logic       upd_team;
   logic [1:0] upd_cmd;

   modport master (output upd_valid, output upd_team, output upd_cmd, input upd_ready);
   modport slave  (input upd_valid, input upd_team, input upd_cmd, output upd_ready);
endinterface

// File: rtl/scoreboard_display_ctrl.sv
// Two-team BCD scoreboard with a one-busy-cycle update handshake and a
// free-running 4-digit multiplexed display scan (dead time + leading-zero blank).
module scoreboard_display_ctrl #(
   parameter int CLK_DIV  = 50000,
   parameter int DEAD     = 2,
   parameter bit LZ_BLANK = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   scoreboard_display_ctrl_if.slave   upd,
   output logic [3:0]                 digit_sel,
   output logic [3:0]                 nibble
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic {IDLE, APPLY} state_t;

   state_t        state_q, state_d;
   logic          team_q, team_d;
   logic [1:0]    cmd_q, cmd_d;
   logic [3:0]    a_t_q, a_u_q, b_t_q, b_u_q;
   logic [3:0]    a_t_d, a_u_d, b_t_d, b_u_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    nib_q, nib_d;
   logic          accept;

   // One BCD score step: increment wraps 99->00, decrement saturates at 00.
   function automatic logic [7:0] bcd_step(input logic [3:0] t, input logic [3:0] u,
                                           input logic [1:0] cmd);
      logic [3:0] nt, nu;
      nt = t;
      nu = u;
      case (cmd)
         2'b00: begin
            if (u == 4'd9) begin
               nu = 4'd0;
               nt = (t == 4'd9) ? 4'd0 : t + 4'd1;
            end else begin
               nu = u + 4'd1;
            end
         end
         2'b01: begin
            if (u != 4'd0) begin
               nu = u - 4'd1;
            end else if (t != 4'd0) begin
               nu = 4'd9;
               nt = t - 4'd1;
            end
         end
         default: begin
            nt = 4'd0;
            nu = 4'd0;
         end
      endcase
      return {nt, nu};
   endfunction

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: every accepted command costs exactly one APPLY cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (upd.upd_valid) state_d = APPLY;
         APPLY:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      upd.upd_ready = (state_q == IDLE);
      accept        = upd.upd_valid && (state_q == IDLE);
   end

   // Command latch and score update; clear-both ignores the team bit.
   always_comb begin
      team_d = team_q;
      cmd_d  = cmd_q;
      a_t_d  = a_t_q;
      a_u_d  = a_u_q;
      b_t_d  = b_t_q;
      b_u_d  = b_u_q;
      if (accept) begin
         team_d = upd.upd_team;
         cmd_d  = upd.upd_cmd;
      end
      if (state_q == APPLY) begin
         if (cmd_q == 2'b11) begin
            a_t_d = 4'd0; a_u_d = 4'd0;
            b_t_d = 4'd0; b_u_d = 4'd0;
         end else if (team_q) begin
            {b_t_d, b_u_d} = bcd_step(b_t_q, b_u_q, cmd_q);
         end else begin
            {a_t_d, a_u_d} = bcd_step(a_t_q, a_u_q, cmd_q);
         end
      end
   end

   // Scan timing; nibble is fetched for the index that will be current after
   // this edge so it is valid from the first cycle of every slot.
   always_comb begin
      cnt_d = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + 1'b1;
      idx_d = (cnt_q == CW'(CLK_DIV - 1)) ? idx_q + 2'd1 : idx_q;
      case (idx_d)
         2'd0:    nib_d = a_u_q;
         2'd1:    nib_d = a_t_q;
         2'd2:    nib_d = b_u_q;
         default: nib_d = b_t_q;
      endcase
   end

   // Datapath and scan registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         team_q <= 1'b0;
         cmd_q  <= 2'b00;
         a_t_q  <= 4'd0;
         a_u_q  <= 4'd0;
         b_t_q  <= 4'd0;
         b_u_q  <= 4'd0;
         cnt_q  <= '0;
         idx_q  <= 2'd0;
         nib_q  <= 4'd0;
      end else begin
         team_q <= team_d;
         cmd_q  <= cmd_d;
         a_t_q  <= a_t_d;
         a_u_q  <= a_u_d;
         b_t_q  <= b_t_d;
         b_u_q  <= b_u_d;
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         nib_q  <= nib_d;
      end
   end

   // Anode drive: dead time at slot start, zero tens digits stay dark.
   always_comb begin
      if (cnt_q < CW'(DEAD))
         digit_sel = 4'b1111;
      else if (LZ_BLANK && idx_q[0] && (nib_q == 4'd0))
         digit_sel = 4'b1111;
      else
         digit_sel = ~(4'b0001 << idx_q);
      nibble = nib_q;
   end
endmodule

// File: tb/tb_scoreboard_display_ctrl.sv
// Bench: two DUTs (leading-zero blank on/off) sharing one command stream,
// checked every cycle against an integer-score model plus literal spot checks.
module tb_scoreboard_display_ctrl;
   localparam int CD = 4;
   localparam int DT = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       valid = 1'b0;
   logic       team = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic [3:0] sel1, nib1, sel0, nib0;
   bit         chk_en = 1'b0;
   int         n_chk = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   scoreboard_display_ctrl_if u_if1 ();
   scoreboard_display_ctrl_if u_if0 ();
   assign u_if1.upd_valid = valid;
   assign u_if1.upd_team  = team;
   assign u_if1.upd_cmd   = cmd;
   assign u_if0.upd_valid = valid;
   assign u_if0.upd_team  = team;
   assign u_if0.upd_cmd   = cmd;

   scoreboard_display_ctrl #(.CLK_DIV(CD), .DEAD(DT), .LZ_BLANK(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .upd(u_if1.slave), .digit_sel(sel1), .nibble(nib1));
   scoreboard_display_ctrl #(.CLK_DIV(CD), .DEAD(DT), .LZ_BLANK(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .upd(u_if0.slave), .digit_sel(sel0), .nibble(nib0));

   // ---------------- model: scores as plain integers 0..99 ----------------
   int sa, sb, pa, pb, mcyc, pcmd;
   bit m_busy, pteam;

   function automatic int step(int s, int c);
      case (c)
         0:       return (s == 99) ? 0 : s + 1;
         1:       return (s == 0) ? 0 : s - 1;
         default: return 0;
      endcase
   endfunction

   function automatic int dig(int i, int a, int b);
      case (i)
         0:       return a % 10;
         1:       return a / 10;
         2:       return b % 10;
         default: return b / 10;
      endcase
   endfunction

   function automatic logic [3:0] esel(int slot, int i, int d, bit lz);
      logic [3:0] one;
      one = 4'b0001;
      if (slot < DT) return 4'b1111;
      if (lz && (i % 2 == 1) && d == 0) return 4'b1111;
      return ~(one << i);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa <= 0; sb <= 0; pa <= 0; pb <= 0; mcyc <= 0;
         m_busy <= 1'b0; pcmd <= 0; pteam <= 1'b0;
      end else begin
         mcyc <= mcyc + 1;
         pa   <= sa;
         pb   <= sb;
         if (m_busy) begin
            m_busy <= 1'b0;
            if (pcmd == 3) begin
               sa <= 0; sb <= 0;
            end else if (pteam) sb <= step(sb, pcmd);
            else                sa <= step(sa, pcmd);
         end else if (valid) begin
            m_busy <= 1'b1;
            pcmd   <= int'(cmd);
            pteam  <= team;
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Every-cycle comparison of both DUTs against the model.
   always @(negedge clk) begin
      int slot, idx, d;
      if (chk_en) begin
         slot = mcyc % CD;
         idx  = (mcyc / CD) % 4;
         d    = dig(idx, pa, pb);
         check("ready1", int'(u_if1.upd_ready), int'(!m_busy));
         check("ready0", int'(u_if0.upd_ready), int'(!m_busy));
         check("nib1", int'(nib1), d);
         check("nib0", int'(nib0), d);
         check("sel1", int'(sel1), int'(esel(slot, idx, d, 1'b1)));
         check("sel0", int'(sel0), int'(esel(slot, idx, d, 1'b0)));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_cmd(input bit t, input logic [1:0] c);
      valid = 1'b1; team = t; cmd = c;
      @(negedge clk);
      valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic repeat_cmd(input bit t, input logic [1:0] c, input int n);
      for (int k = 0; k < n; k++) do_cmd(t, c);
   endtask

   // Wait (bounded) for the first lit cycle of digit slot i; returns at negedge+1.
   task automatic wait_slot(input int i);
      bit found;
      found = 1'b0;
      for (int k = 0; k < 4 * CD + 2 && !found; k++) begin
         @(negedge clk); #1;
         if (((mcyc / CD) % 4) == i && (mcyc % CD) == DT) found = 1'b1;
      end
      if (!found) check("wait_slot_timeout", 0, 1);
   endtask

   logic [3:0] exp28 [16];
   logic [3:0] exp33 [4];
   logic [3:0] got28 [16];
   int         rdy_seq [4];

   initial begin
      exp28 = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF,
                4'hF, 4'hB, 4'hB, 4'hB, 4'hF, 4'hF, 4'hF, 4'hF};
      exp33 = '{4'hE, 4'hD, 4'hB, 4'h7};

      // reset values
      #1 rst_n = 1'b0;
      #2 chk_en = 1'b1;
      @(negedge clk); #1;
      check("rst_ready", int'(u_if1.upd_ready), 1);
      check("rst_sel", int'(sel1), 15);
      check("rst_nib", int'(nib1), 0);
      @(negedge clk); #2 rst_n = 1'b1;

      // scan sequence at 00/00 from release
      #1 got28[0] = sel1;
      for (int k = 1; k < 16; k++) begin
         @(negedge clk); #1 got28[k] = sel1;
      end
      for (int k = 0; k < 16; k++) check($sformatf("scan00_%0d", k), int'(got28[k]), int'(exp28[k]));

      // A 09 -> 10 with one busy cycle
      repeat_cmd(1'b0, 2'b00, 9);
      valid = 1'b1; team = 1'b0; cmd = 2'b00;
      @(negedge clk); #1;
      check("busy_one_cycle", int'(u_if1.upd_ready), 0);
      valid = 1'b0;
      @(negedge clk); #1;
      check("ready_back", int'(u_if1.upd_ready), 1);
      check("model_a10", sa, 10);
      wait_slot(1);
      check("a_tens_sel", int'(sel1), 4'b1101);
      check("a_tens_nib", int'(nib1), 1);

      // B wrap, B saturate, A borrow
      do_cmd(1'b0, 2'b11);
      repeat_cmd(1'b1, 2'b00, 99);
      check("model_b99", sb, 99);
      wait_slot(3);
      check("b_tens9_sel", int'(sel1), 4'b0111);
      check("b_tens9_nib", int'(nib1), 9);
      do_cmd(1'b1, 2'b00);
      check("model_b_wrap", sb, 0);
      wait_slot(2);
      check("b_units0_nib", int'(nib1), 0);
      wait_slot(3);
      check("b_tens_blank", int'(sel1), 4'b1111);
      do_cmd(1'b1, 2'b01);
      check("model_b_sat", sb, 0);
      do_cmd(1'b0, 2'b10);
      repeat_cmd(1'b0, 2'b00, 20);
      do_cmd(1'b0, 2'b01);
      check("model_a19", sa, 19);
      wait_slot(0);
      check("a19_units", int'(nib1), 9);
      wait_slot(1);
      check("a19_tens", int'(nib1), 1);

      // held valid for 4 cycles -> two accepts
      do_cmd(1'b0, 2'b10);
      valid = 1'b1; team = 1'b0; cmd = 2'b00;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1 rdy_seq[k] = int'(u_if1.upd_ready);
      end
      valid = 1'b0;
      check("hold_rdy0", rdy_seq[0], 0);
      check("hold_rdy1", rdy_seq[1], 1);
      check("hold_rdy2", rdy_seq[2], 0);
      check("hold_rdy3", rdy_seq[3], 1);
      check("model_a02", sa, 2);
      wait_slot(0);
      check("a02_units", int'(nib1), 2);

      // clear both, then reset in the middle of APPLY
      do_cmd(1'b0, 2'b10);
      repeat_cmd(1'b0, 2'b00, 45);
      repeat_cmd(1'b1, 2'b00, 12);
      wait_slot(0);
      check("a45_units", int'(nib1), 5);
      @(negedge clk);
      do_cmd(1'b1, 2'b11);
      check("model_clear_a", sa, 0);
      check("model_clear_b", sb, 0);
      wait_slot(2);
      check("cleared_b_units", int'(nib1), 0);
      @(negedge clk);
      valid = 1'b1; team = 1'b0; cmd = 2'b00;
      @(negedge clk);
      valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_apply_ready", int'(u_if1.upd_ready), 1);
      check("rst_apply_sel", int'(sel1), 15);
      check("rst_apply_nib", int'(nib1), 0);
      @(negedge clk); #2 rst_n = 1'b1;
      check("model_rst_a", sa, 0);
      wait_slot(0);
      check("post_rst_a_units", int'(nib1), 0);

      // no leading-zero blanking: 05/00 lights all four digits
      repeat_cmd(1'b0, 2'b00, 5);
      for (int i = 0; i < 4; i++) begin
         wait_slot(i);
         check($sformatf("lz0_sel%0d", i), int'(sel0), int'(exp33[i]));
         check($sformatf("lz0_nib%0d", i), int'(nib0), (i == 0) ? 5 : 0);
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
